// File: rtl/decode_stage_hz_if.sv
// Bundle of the decode-stage D-side inputs, W-side writeback and E-side outputs.
// Latency: none (wires only); StallF/StallD are combinational from the stage.
// Backpressure: StallF/StallD flow back to fetch, everything else is forward.
// Ports: master = upstream/harness side, slave = decode_stage_hz side.
interface decode_stage_hz_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int ALUW = 3
);
    localparam int RW = $clog2(NREG);

    // D stage
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            FlushE;
    // W stage writeback
    logic            RegWriteW;
    logic [RW-1:0]   RDW;
    logic [XLEN-1:0] ResultW;
    // Hazard feedback
    logic            StallF;
    logic            StallD;
    // E stage
    logic            ValidE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [ALUW-1:0] ALUControlE;
    logic [RW-1:0]   Rs1E;
    logic [RW-1:0]   Rs2E;
    logic [RW-1:0]   RdE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;

    modport master (
        output InstrD, PCD, PCPlus4D, ValidD, FlushE, RegWriteW, RDW, ResultW,
        input  StallF, StallD, ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, ValidD, FlushE, RegWriteW, RDW, ResultW,
        output StallF, StallD, ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_stage_hz.sv
// Decode stage: control decode, register file, immediate extend, ID/EX register, load-use detect.
// Latency: 1 cycle D->E; StallF/StallD combinational from E state and InstrD.
// Backpressure: load-use in E raises StallF/StallD for one cycle and injects a bubble; FlushE wins.
// Ports: clk, rst (sync, active-high), bus (decode_stage_hz_if.slave).
// Option: DECODE_WB_BYPASS_EN makes the register file write-first (W data bypassed into the read ports).
module decode_stage_hz #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int ALUW = 3
) (
    input  logic              clk,
    input  logic              rst,
    decode_stage_hz_if.slave  bus
);
    localparam int RW = $clog2(NREG);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [ALUW-1:0] alu_ctrl;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } ex_t;

    // ---------------- control decode ----------------
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]      result_src_d, imm_src_d, alu_op_d;
    logic [ALUW-1:0] alu_ctrl_d;

    assign op       = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign funct7b5 = bus.InstrD[30];

    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_src_d    = 1'b0;
        result_src_d = 2'b00;
        imm_src_d    = 2'b00;
        alu_op_d     = 2'b00;
        case (op)
            7'b0000011: begin reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01; end // lw
            7'b0100011: begin mem_write_d = 1'b1; alu_src_d = 1'b1; imm_src_d = 2'b01;     end // sw
            7'b0110011: begin reg_write_d = 1'b1; alu_op_d = 2'b10;                        end // R-type
            7'b1100011: begin branch_d = 1'b1; imm_src_d = 2'b10; alu_op_d = 2'b01;       end // beq
            7'b0010011: begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = 2'b10;      end // I-type ALU
            7'b1101111: begin reg_write_d = 1'b1; jump_d = 1'b1; imm_src_d = 2'b11;
                              result_src_d = 2'b10;                                        end // jal
            default: ;
        endcase
    end

    always_comb begin
        alu_ctrl_d = ALUW'(3'b000);
        case (alu_op_d)
            2'b01: alu_ctrl_d = ALUW'(3'b001);
            2'b10: begin
                case (funct3)
                    // Only R-type has a funct7 sub bit; op[5] separates it from addi.
                    3'b000:  alu_ctrl_d = (op[5] & funct7b5) ? ALUW'(3'b001) : ALUW'(3'b000);
                    3'b010:  alu_ctrl_d = ALUW'(3'b101);
                    3'b110:  alu_ctrl_d = ALUW'(3'b011);
                    3'b111:  alu_ctrl_d = ALUW'(3'b010);
                    default: alu_ctrl_d = ALUW'(3'b000);
                endcase
            end
            default: alu_ctrl_d = ALUW'(3'b000);
        endcase
    end

    // ---------------- immediate ----------------
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext_d;

    always_comb begin
        imm32 = '0;
        case (imm_src_d)
            2'b00: imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
            2'b01: imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            2'b10: imm32 = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                            bus.InstrD[11:8], 1'b0};
            2'b11: imm32 = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                            bus.InstrD[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext_d = XLEN'($signed(imm32));

    // ---------------- register file ----------------
    logic [RW-1:0]   rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic            wb_en;
    logic [XLEN-1:0] rd1_d, rd2_d;

    assign rs1_d = bus.InstrD[15 +: RW];
    assign rs2_d = bus.InstrD[20 +: RW];
    assign rd_d  = bus.InstrD[7 +: RW];
    assign wb_en = bus.RegWriteW && (bus.RDW != '0);

    always_comb begin
        rf_d = rf_q;
        if (wb_en) rf_d[bus.RDW] = bus.ResultW;
    end

    always_ff @(posedge clk) begin
        if (rst) rf_q <= '{default: '0};
        else     rf_q <= rf_d;
    end

    always_comb begin
        rd1_d = (rs1_d == '0) ? '0 : rf_q[rs1_d];
        rd2_d = (rs2_d == '0) ? '0 : rf_q[rs2_d];
`ifdef DECODE_WB_BYPASS_EN
        // wb_en already excludes x0, so the zero register stays zero.
        if (wb_en && bus.RDW == rs1_d) rd1_d = bus.ResultW;
        if (wb_en && bus.RDW == rs2_d) rd2_d = bus.ResultW;
`endif
    end

    // ---------------- hazard + ID/EX register ----------------
    ex_t  ex_q, ex_d;
    logic hazard_d;

    // Rs2 is compared even for formats without rs2; a spurious stall is harmless.
    assign hazard_d = bus.ValidD & ex_q.valid & (ex_q.result_src == 2'b01) & (ex_q.rd != '0) &
                      ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d));

    assign bus.StallF = hazard_d & ~bus.FlushE;
    assign bus.StallD = hazard_d & ~bus.FlushE;

    always_comb begin
        ex_d = '0;  // bubble: every field zero
        if (!(bus.FlushE || hazard_d)) begin
            ex_d.valid      = bus.ValidD;
            ex_d.reg_write  = reg_write_d & bus.ValidD;
            ex_d.mem_write  = mem_write_d & bus.ValidD;
            ex_d.jump       = jump_d & bus.ValidD;
            ex_d.branch     = branch_d & bus.ValidD;
            ex_d.alu_src    = alu_src_d;
            ex_d.result_src = result_src_d;
            ex_d.alu_ctrl   = alu_ctrl_d;
            ex_d.rs1        = rs1_d;
            ex_d.rs2        = rs2_d;
            ex_d.rd         = rd_d;
            ex_d.rd1        = rd1_d;
            ex_d.rd2        = rd2_d;
            ex_d.imm        = imm_ext_d;
            ex_d.pc         = bus.PCD;
            ex_d.pc4        = bus.PCPlus4D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign bus.ValidE      = ex_q.valid;
    assign bus.RegWriteE   = ex_q.reg_write;
    assign bus.MemWriteE   = ex_q.mem_write;
    assign bus.JumpE       = ex_q.jump;
    assign bus.BranchE     = ex_q.branch;
    assign bus.ALUSrcE     = ex_q.alu_src;
    assign bus.ResultSrcE  = ex_q.result_src;
    assign bus.ALUControlE = ex_q.alu_ctrl;
    assign bus.Rs1E        = ex_q.rs1;
    assign bus.Rs2E        = ex_q.rs2;
    assign bus.RdE         = ex_q.rd;
    assign bus.RD1_E       = ex_q.rd1;
    assign bus.RD2_E       = ex_q.rd2;
    assign bus.ImmExtE     = ex_q.imm;
    assign bus.PCE         = ex_q.pc;
    assign bus.PCPlus4E    = ex_q.pc4;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: directed cases then randomized instruction stream.
// Expected E-stage contents come from instruction builders that know what they encoded.
module tb_decode_stage_hz;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int ALUW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_hz_if #(.XLEN(XLEN), .NREG(NREG), .ALUW(ALUW)) bus();
    decode_stage_hz #(.XLEN(XLEN), .NREG(NREG), .ALUW(ALUW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // What an instruction should decode to, filled in by the builder that encoded it.
    typedef struct packed {
        logic [31:0] instr;
        logic        rw, mw, jmp, br, alusrc;
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
        logic [31:0] imm;
        logic        imm_chk;  // R-type carries no immediate
    } dec_t;

    typedef struct packed {
        logic        valid, rw, mw, jmp, br, alusrc;
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic        imm_chk;
    } ex_t;

    int          n_chk = 0;
    int          n_bad = 0;
    ex_t         m_e = '0;
    logic [31:0] m_rf [32];
    logic        m_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic dec_t mk_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        dec_t d = '0;
        d.instr = {imm, rs1, 3'b000, rd, 7'b0010011};
        d.rw = 1'b1; d.alusrc = 1'b1;
        d.imm = 32'($signed(imm)); d.imm_chk = 1'b1;
        return d;
    endfunction

    function automatic dec_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        dec_t d = '0;
        d.instr = {imm, rs1, 3'b010, rd, 7'b0000011};
        d.rw = 1'b1; d.alusrc = 1'b1; d.rsrc = 2'b01;
        d.imm = 32'($signed(imm)); d.imm_chk = 1'b1;
        return d;
    endfunction

    function automatic dec_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        dec_t d = '0;
        d.instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        d.mw = 1'b1; d.alusrc = 1'b1;
        d.imm = 32'($signed(imm)); d.imm_chk = 1'b1;
        return d;
    endfunction

    // sel: 0 add, 1 sub, 2 and, 3 or, 4 slt
    function automatic dec_t mk_r(input int sel, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        dec_t d = '0;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = 7'b0000000;
        case (sel)
            1:       begin f7 = 7'b0100000; f3 = 3'b000; d.aluc = 3'b001; end
            2:       begin f3 = 3'b111; d.aluc = 3'b010; end
            3:       begin f3 = 3'b110; d.aluc = 3'b011; end
            4:       begin f3 = 3'b010; d.aluc = 3'b101; end
            default: begin f3 = 3'b000; d.aluc = 3'b000; end
        endcase
        d.instr = {f7, rs2, rs1, f3, rd, 7'b0110011};
        d.rw = 1'b1;
        return d;
    endfunction

    function automatic dec_t mk_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] k);
        dec_t d = '0;
        logic [12:0] b;
        b = {k, 1'b0};
        d.instr = {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'b1100011};
        d.br = 1'b1; d.aluc = 3'b001;
        d.imm = 32'($signed(b)); d.imm_chk = 1'b1;
        return d;
    endfunction

    function automatic dec_t mk_jal(input logic [4:0] rd, input logic [19:0] k);
        dec_t d = '0;
        logic [20:0] j;
        j = {k, 1'b0};
        d.instr = {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
        d.rw = 1'b1; d.jmp = 1'b1; d.rsrc = 2'b10;
        d.imm = 32'($signed(j)); d.imm_chk = 1'b1;
        return d;
    endfunction

    // Small register range so load-use collisions happen often.
    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic dec_t mk_rand();
        case ($urandom_range(0, 5))
            0:       return mk_addi(rreg(), rreg(), 12'($urandom));
            1:       return mk_lw(rreg(), rreg(), 12'($urandom));
            2:       return mk_sw(rreg(), rreg(), 12'($urandom));
            3:       return mk_beq(rreg(), rreg(), 12'($urandom));
            4:       return mk_jal(rreg(), 20'($urandom));
            default: return mk_r(int'($urandom_range(0, 4)), rreg(), rreg(), rreg());
        endcase
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic rww,
                                            input logic [4:0] rdw, input logic [31:0] res);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (rww && rdw != 5'd0 && rdw == a) return res;
`endif
        return m_rf[a];
    endfunction

    // One clock: drive D/W inputs, check stall, advance the model, check E after the edge.
    task automatic cycle(input logic r, input dec_t d, input logic [31:0] pc, input logic vd,
                         input logic fl, input logic rww, input logic [4:0] rdw, input logic [31:0] res);
        logic [4:0] rs1, rs2, rd;
        logic       hz;
        ex_t        nx;
        rs1 = d.instr[19:15];
        rs2 = d.instr[24:20];
        rd  = d.instr[11:7];
        @(negedge clk);
        rst           = r;
        bus.InstrD    = d.instr;
        bus.PCD       = pc;
        bus.PCPlus4D  = pc + 32'd4;
        bus.ValidD    = vd;
        bus.FlushE    = fl;
        bus.RegWriteW = rww;
        bus.RDW       = rdw;
        bus.ResultW   = res;
        #1;
        hz = vd && m_e.valid && m_e.rsrc == 2'b01 && m_e.rd != 5'd0 && (m_e.rd == rs1 || m_e.rd == rs2);
        m_stall = hz && !fl;
        check("stall_d", bus.StallD, m_stall);
        check("stall_f", bus.StallF, m_stall);
        nx = '0;
        nx.imm_chk = 1'b1;
        if (!r && !fl && !hz) begin
            nx.valid  = vd;
            nx.rw     = d.rw & vd;
            nx.mw     = d.mw & vd;
            nx.jmp    = d.jmp & vd;
            nx.br     = d.br & vd;
            nx.alusrc = d.alusrc;
            nx.rsrc   = d.rsrc;
            nx.aluc   = d.aluc;
            nx.rs1    = rs1;
            nx.rs2    = rs2;
            nx.rd     = rd;
            nx.rd1    = rf_read(rs1, rww, rdw, res);
            nx.rd2    = rf_read(rs2, rww, rdw, res);
            nx.imm    = d.imm;
            nx.imm_chk = d.imm_chk;
            nx.pc     = pc;
            nx.pc4    = pc + 32'd4;
        end
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (rww && rdw != 5'd0) begin
            m_rf[rdw] = res;
        end
        m_e = nx;
        @(posedge clk);
        #1;
        check("valid_e",    bus.ValidE,      m_e.valid);
        check("regwrite_e", bus.RegWriteE,   m_e.rw);
        check("memwrite_e", bus.MemWriteE,   m_e.mw);
        check("jump_e",     bus.JumpE,       m_e.jmp);
        check("branch_e",   bus.BranchE,     m_e.br);
        check("alusrc_e",   bus.ALUSrcE,     m_e.alusrc);
        check("resultsrc_e", bus.ResultSrcE, m_e.rsrc);
        check("aluctrl_e",  bus.ALUControlE, m_e.aluc);
        check("rs1_e",      bus.Rs1E,        m_e.rs1);
        check("rs2_e",      bus.Rs2E,        m_e.rs2);
        check("rd_e",       bus.RdE,         m_e.rd);
        check("rd1_e",      bus.RD1_E,       m_e.rd1);
        check("rd2_e",      bus.RD2_E,       m_e.rd2);
        if (m_e.imm_chk) check("imm_e", bus.ImmExtE, m_e.imm);
        check("pc_e",       bus.PCE,         m_e.pc);
        check("pc4_e",      bus.PCPlus4E,    m_e.pc4);
    endtask

    initial begin
        dec_t        cur;
        logic [31:0] cur_pc;
        logic        vd, fl, rr, rww;
        logic [4:0]  rdw;

        // First reset edge brings the DUT out of X; the model starts from the reset state.
        rst = 1'b1;
        bus.InstrD = $urandom; bus.PCD = $urandom; bus.PCPlus4D = $urandom;
        bus.ValidD = 1'b1; bus.FlushE = 1'b0; bus.RegWriteW = 1'b0; bus.RDW = '0; bus.ResultW = '0;
        @(posedge clk);
        #1;
        check("rst_valid", bus.ValidE, 1'b0);
        cycle(1'b1, mk_rand(), $urandom, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("rst_stall", bus.StallD, 1'b0);

        // First post-reset edge loads addi x5,x0,7.
        cycle(1'b0, mk_addi(5'd5, 5'd0, 12'd7), 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("addi_instr", bus.InstrD, 32'h0070_0293);
        check("addi_rd",    bus.RdE, 5'd5);
        check("addi_imm",   bus.ImmExtE, 32'd7);
        check("addi_alusrc", bus.ALUSrcE, 1'b1);
        check("addi_rw",    bus.RegWriteE, 1'b1);
        check("addi_pc",    bus.PCE, 32'h100);
        check("addi_pc4",   bus.PCPlus4E, 32'h104);
        check("addi_valid", bus.ValidE, 1'b1);

        // Load-use: lw x6,0(x1) then add x7,x6,x2 -> one bubble, then add enters E.
        cycle(1'b0, mk_lw(5'd6, 5'd1, 12'd0), 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, mk_r(0, 5'd7, 5'd6, 5'd2), 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lu_stall",  m_stall, 1'b1);
        check("lu_bubble", bus.ValidE, 1'b0);
        cycle(1'b0, mk_r(0, 5'd7, 5'd6, 5'd2), 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lu_release", bus.StallD, 1'b0);
        check("lu_rs1",     bus.Rs1E, 5'd6);
        check("lu_valid",   bus.ValidE, 1'b1);

        // Flush beats the stall.
        cycle(1'b0, mk_lw(5'd6, 5'd1, 12'd0), 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, mk_r(0, 5'd7, 5'd6, 5'd2), 32'h304, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        check("fl_stall",  bus.StallD, 1'b0);
        check("fl_bubble", bus.ValidE, 1'b0);
        cycle(1'b0, mk_addi(5'd8, 5'd0, 12'd1), 32'h308, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("fl_adv", bus.RdE, 5'd8);

        // Same-cycle W->D conflict on x9.
        cycle(1'b0, mk_r(0, 5'd10, 5'd9, 5'd0), 32'h400, 1'b1, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
`ifdef DECODE_WB_BYPASS_EN
        check("byp_rd1", bus.RD1_E, 32'hDEAD_BEEF);
`else
        check("byp_rd1", bus.RD1_E, 32'd0);
`endif
        cycle(1'b0, mk_r(0, 5'd10, 5'd9, 5'd0), 32'h404, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("byp_later", bus.RD1_E, 32'hDEAD_BEEF);

        // x0 protection.
        cycle(1'b0, mk_addi(5'd0, 5'd0, 12'd0), 32'h500, 1'b1, 1'b0, 1'b1, 5'd0, 32'h55);
        cycle(1'b0, mk_r(0, 5'd11, 5'd0, 5'd0), 32'h504, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("x0_rd1", bus.RD1_E, 32'd0);
        cycle(1'b0, mk_lw(5'd0, 5'd1, 12'd0), 32'h508, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, mk_r(0, 5'd12, 5'd0, 5'd0), 32'h50C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("x0_nostall", m_stall, 1'b0);
        check("x0_valid", bus.ValidE, 1'b1);

        // Random stream; D holds its instruction while the model says stall.
        cur    = mk_rand();
        cur_pc = 32'h1000;
        vd     = 1'b1;
        repeat (800) begin
            rr  = ($urandom_range(0, 63) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            rww = 1'($urandom_range(0, 1));
            rdw = 5'($urandom_range(0, 9));
            cycle(rr, cur, cur_pc, vd, fl, rww, rdw, $urandom);
            if (!m_stall) begin
                cur    = mk_rand();
                cur_pc = cur_pc + 32'd4;
                vd     = ($urandom_range(0, 7) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage with an ID/EX pipeline register, a valid bit, flush and load-use stall handling. It decodes `InstrD`, reads the register file and generates the immediate. It registers everything into the E stage and detects load-use hazards against the instruction currently in E. It sits between the IF/ID register and the execute stage, and drives `StallF`/`StallD` back to fetch.

## Interface
Parameters:
- `XLEN`, 32 — datapath width (32 or 64); immediates are sign-extended to `XLEN`.
- `NREG`, 32 — number of architectural registers; address width `RW = $clog2(NREG)`.
- `ALUW`, 3 — ALU control width.

Ports (reset is synchronous and active-high; everything is on one clock):
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `InstrD`  in  32  — instruction in D.
- `PCD`, `PCPlus4D`  in  XLEN  — PC and PC+4 of the instruction in D.
- `ValidD`  in  1  — D holds a real instruction.
- `FlushE`  in  1  — kill the instruction entering E (taken branch/jump).
- `RegWriteW`  in  1  — writeback enable.
- `RDW`  in  RW  — writeback destination.
- `ResultW`  in  XLEN  — writeback data.
- `StallF`, `StallD`  out  1  — load-use stall, combinational.
- `ValidE`, `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`  out  1  — registered.
- `ResultSrcE`  out  2  — registered.
- `ALUControlE`  out  ALUW  — registered.
- `Rs1E`, `Rs2E`, `RdE`  out  RW  — registered register addresses, for the forwarding unit.
- `RD1_E`, `RD2_E`, `ImmExtE`, `PCE`, `PCPlus4E`  out  XLEN  — registered.

## Operation
Decode:
- Uses the team `controlUnit` (op/funct3/funct7) and `extend` (ImmSrc); the 32-bit immediate is sign-extended to `XLEN`.
- Field extraction: `Rs1D = InstrD[19:15]`, `Rs2D = InstrD[24:20]`, `RdD = InstrD[11:7]`, each truncated to `RW`.

Register file:
- `NREG` x `XLEN` array with two read ports and one write port.
- Write on posedge `clk` when `RegWriteW && RDW != 0`.
- Register x0 reads 0 always.
- `rst` clears all entries.

Hazard detection (combinational):
- `HazardD = ValidD & ValidE & (ResultSrcE == 2'b01) & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D)`.
- The Rs2 compare is unconditional, even for I-type instructions. This is conservative and intended.
- `StallF = StallD = HazardD & ~FlushE`.

ID/EX register update at posedge `clk`, highest priority first:
1. `rst`: all E outputs are 0.
2. `FlushE`: bubble.
3. `HazardD`: bubble, while D holds its instruction because the upstream stage honours `StallD`.
4. Otherwise: load decoded values; `ValidE <= ValidD`.
   - When `ValidD` is 0, the control fields `RegWriteE`, `MemWriteE`, `JumpE` and `BranchE` load as 0.
   - The data fields load normally.

Bubble definition:
- Every E output goes to 0, data included, so that benches can compare exact values.

## Timing
- Latency: D to E is 1 cycle. `StallF`/`StallD` are combinational from the current E state and `InstrD`.
- Reset values: every E output is 0, and `ValidE = 0`. Therefore `StallF = StallD = 0` through and immediately after reset.
- A load-use hazard produces exactly one bubble. After it, `ResultSrcE != 01` or `ValidE = 0`, so `HazardD` drops and the dependent instruction enters E on the next edge.
- `FlushE` together with `HazardD`: flush wins, stall is suppressed, and D advances normally.
- Register-file write and a same-cycle read of the same register: see Configuration.
- `rst` asserted mid-stall or mid-flush: the E register clears on that edge. Stalls are released in the next cycle.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - Read port `n` returns `ResultW` when `RegWriteW && RDW != 0 && RDW == Rs_nD`.
  - This is a write-first register file; the value enters `RD*_E` on the same edge as the write.
- Not defined:
  - Read ports return the array contents, which is the old value during a same-cycle W→D conflict.
  - Software or NOP padding covers the conflict.

## Test plan
- Reset: assert `rst` for 2 cycles with a random `InstrD` and `ValidD=1` → all E outputs 0 and `StallD=0`. The first post-reset edge loads the decoded instruction.
- Basic decode: `InstrD=addi x5,x0,7` (0x00700293), `PCD=0x100` → next cycle `RdE=5`, `ImmExtE=7`, `ALUSrcE=1`, `RegWriteE=1`, `PCE=0x100`, `PCPlus4E=0x104`, `ValidE=1`.
- Load-use: `lw x6,0(x1)` followed by `add x7,x6,x2` → `StallD=1` for exactly 1 cycle and E holds a bubble (`ValidE=0`). The `add` enters E the following cycle with `Rs1E=6`.
- Flush priority: same load-use pair with `FlushE=1` in the hazard cycle → `StallD=0`, E is a bubble, and D advances.
- WB bypass: write x9=0xDEADBEEF via W while D reads x9 → with `DECODE_WB_BYPASS_EN`, `RD1_E=0xDEADBEEF`; without it, `RD1_E` holds the old value (0 after reset).
- x0 protection: `RegWriteW=1`, `RDW=0`, `ResultW=0x55` → a later read of x0 gives 0, and `lw x0` followed by a dependent instruction raises no stall.
